router_input_fifo: RTL and testbench

- Per-port input stage of the mesh router; one instance per direction (south, west, north, east, core).
- Accepts single-flit packets from the neighbouring router or core over a valid/ready handshake and buffers them in a small FIFO.
- Computes the dimension-ordered (XY) output port for each packet at enqueue.
- Presents the head packet and a one-hot output request to the round-robin arbiter, and pops the head when granted.

---
 rtl/router_input_fifo.sv | 136 +++++++++++++
 tb/tb_router_input_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/router_input_fifo.sv
// Per-port router input buffer: FIFO of single-flit packets with XY route decode at
// enqueue; the head packet and its one-hot output request are presented to the arbiter.
module router_input_fifo #(
   parameter int X         = 0,
   parameter int Y         = 0,
   parameter int IN_PORT   = 0,
   parameter int COORD_W   = 4,
   parameter int PAYLOAD_W = 32,
   parameter int DEPTH     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2*COORD_W+PAYLOAD_W-1:0] in_packet,
   output logic [2*COORD_W+PAYLOAD_W-1:0] out_packet,
   output logic [4:0]                     request,
   input  logic                           grant,
   output logic                           route_err,
   output logic                           grant_err
);
   localparam int PKT_W = 2*COORD_W + PAYLOAD_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [2:0] PORT_S = 3'd0;
   localparam logic [2:0] PORT_W = 3'd1;
   localparam logic [2:0] PORT_N = 3'd2;
   localparam logic [2:0] PORT_E = 3'd3;
   localparam logic [2:0] PORT_C = 3'd4;

   localparam logic [COORD_W-1:0] X_C       = COORD_W'(X);
   localparam logic [COORD_W-1:0] Y_C       = COORD_W'(Y);
   localparam logic [2:0]         IN_PORT_C = 3'(IN_PORT);
   localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(DEPTH);

   logic [PKT_W-1:0]   mem_q       [DEPTH];
   logic [2:0]         route_mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               route_err_q, route_err_d;
   logic               grant_err_q, grant_err_d;
   logic [COORD_W-1:0] dst_x_s, dst_y_s;
   logic [2:0]         route_s;
   logic [2:0]         head_route_s;
   logic               push_s, pop_s, empty_s, uturn_s;

   // XY route decode on the incoming packet: X dimension is resolved first.
   always_comb begin
      dst_x_s = in_packet[PKT_W-1 -: COORD_W];
      dst_y_s = in_packet[PKT_W-COORD_W-1 -: COORD_W];
      if (dst_x_s > X_C) begin
         route_s = PORT_E;
      end else if (dst_x_s < X_C) begin
         route_s = PORT_W;
      end else if (dst_y_s > Y_C) begin
         route_s = PORT_N;
      end else if (dst_y_s < Y_C) begin
         route_s = PORT_S;
      end else begin
         route_s = PORT_C;
      end
   end

   // Handshake qualification; in_ready deliberately ignores grant.
   always_comb begin
      empty_s  = (count_q == CNT_W'(0));
      in_ready = ~rst & (count_q != DEPTH_C);
      push_s   = in_valid & in_ready;
      pop_s    = grant & ~empty_s;
      uturn_s  = push_s & (route_s == IN_PORT_C) & (IN_PORT_C != PORT_C);
   end

   // Head presentation: packet and one-hot request straight from storage.
   always_comb begin
      head_route_s = route_mem_q[rd_ptr_q];
      out_packet   = mem_q[rd_ptr_q];
      request      = 5'b00000;
      if (!empty_s) begin
         case (head_route_s)
            PORT_S:  request = 5'b00001;
            PORT_W:  request = 5'b00010;
            PORT_N:  request = 5'b00100;
            PORT_E:  request = 5'b01000;
            PORT_C:  request = 5'b10000;
            default: request = 5'b00000;
         endcase
      end else begin
         request = 5'b00000;
      end
   end

   // Next-state for pointers, occupancy and sticky error flags.
   always_comb begin
      wr_ptr_d    = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d    = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      count_d     = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      route_err_d = route_err_q | uturn_s;
      grant_err_d = grant_err_q | (grant & empty_s);
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= PTR_W'(0);
         rd_ptr_q    <= PTR_W'(0);
         count_q     <= CNT_W'(0);
         route_err_q <= 1'b0;
         grant_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         route_err_q <= route_err_d;
         grant_err_q <= grant_err_d;
      end
   end

   // Packet storage is not reset; the route code is stored alongside each packet.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q]       <= in_packet;
         route_mem_q[wr_ptr_q] <= route_s;
      end
   end

   assign route_err = route_err_q;
   assign grant_err = grant_err_q;

endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench: core-port instance at (2,2) and east-port instance at (1,1).
module tb_router_input_fifo;
   logic        clk;
   logic        rst;
   logic        a_valid, a_ready, a_grant, a_rerr, a_gerr;
   logic [39:0] a_pkt, a_out;
   logic [4:0]  a_req;
   logic        b_valid, b_ready, b_grant, b_rerr, b_gerr;
   logic [39:0] b_pkt, b_out;
   logic [4:0]  b_req;
   int          n_cmp;
   int          n_err;

   router_input_fifo #(.X(2), .Y(2), .IN_PORT(4), .COORD_W(4), .PAYLOAD_W(32), .DEPTH(4)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_packet(a_pkt),
      .out_packet(a_out), .request(a_req), .grant(a_grant), .route_err(a_rerr), .grant_err(a_gerr));

   router_input_fifo #(.X(1), .Y(1), .IN_PORT(3), .COORD_W(4), .PAYLOAD_W(32), .DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_packet(b_pkt),
      .out_packet(b_out), .request(b_req), .grant(b_grant), .route_err(b_rerr), .grant_err(b_gerr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [39:0] mk(input int dx, input int dy, input logic [31:0] p);
      return {4'(dx), 4'(dy), p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          rx [5];
      int          ry [5];
      logic [4:0]  rq [5];
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      a_valid = 1'b0; a_grant = 1'b0; a_pkt = 40'h0;
      b_valid = 1'b0; b_grant = 1'b0; b_pkt = 40'h0;
      rx[0] = 3;  ry[0] = 0; rq[0] = 5'b01000;
      rx[1] = 0;  ry[1] = 3; rq[1] = 5'b00010;
      rx[2] = 2;  ry[2] = 3; rq[2] = 5'b00100;
      rx[3] = 2;  ry[3] = 1; rq[3] = 5'b00001;
      rx[4] = 15; ry[4] = 2; rq[4] = 5'b01000;

      // Reset state
      tick();
      tick();
      chk("rst_ready", 64'(a_ready), 64'(1'b0));
      chk("rst_req",   64'(a_req),   64'(5'b00000));
      chk("rst_rerr",  64'(a_rerr),  64'(1'b0));
      chk("rst_gerr",  64'(a_gerr),  64'(1'b0));
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(a_ready), 64'(1'b1));

      // Single packet to the local core on instance B at (1,1)
      b_valid = 1'b1; b_pkt = mk(1, 1, 32'hA5);
      tick();
      b_valid = 1'b0;
      chk("single_req", 64'(b_req), 64'(5'b10000));
      chk("single_out", 64'(b_out), 64'(mk(1, 1, 32'hA5)));
      chk("single_rerr", 64'(b_rerr), 64'(1'b0));
      b_grant = 1'b1;
      tick();
      b_grant = 1'b0;
      chk("single_pop_req", 64'(b_req), 64'(5'b00000));
      chk("single_gerr", 64'(b_gerr), 64'(1'b0));

      // Route decode on instance A at (2,2)
      for (int i = 0; i < 5; i++) begin
         a_valid = 1'b1; a_pkt = mk(rx[i], ry[i], 32'(i + 16));
         tick();
         a_valid = 1'b0;
         chk("route_req", 64'(a_req), 64'(rq[i]));
         a_grant = 1'b1;
         tick();
         a_grant = 1'b0;
         chk("route_pop_req", 64'(a_req), 64'(5'b00000));
      end
      chk("route_rerr", 64'(a_rerr), 64'(1'b0));

      // Fill to DEPTH with a fifth packet held off by backpressure
      a_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_pkt = mk(3, 2, 32'(i));
         chk("fill_ready", 64'(a_ready), 64'(1'b1));
         tick();
      end
      a_pkt = mk(3, 2, 32'd5);
      chk("full_ready", 64'(a_ready), 64'(1'b0));
      tick();
      chk("full_hold_ready", 64'(a_ready), 64'(1'b0));
      chk("full_head", 64'(a_out), 64'(mk(3, 2, 32'd1)));
      a_grant = 1'b1;
      tick();
      a_grant = 1'b0;
      chk("freed_ready", 64'(a_ready), 64'(1'b1));
      chk("freed_head", 64'(a_out), 64'(mk(3, 2, 32'd2)));
      tick();
      a_valid = 1'b0;
      chk("refull_ready", 64'(a_ready), 64'(1'b0));
      for (int i = 2; i <= 5; i++) begin
         chk("drain_out", 64'(a_out), 64'(mk(3, 2, 32'(i))));
         chk("drain_req", 64'(a_req), 64'(5'b01000));
         a_grant = 1'b1;
         tick();
         a_grant = 1'b0;
      end
      chk("drained_req",   64'(a_req),   64'(5'b00000));
      chk("drained_ready", 64'(a_ready), 64'(1'b1));

      // Simultaneous push and pop at count 2 for 10 cycles
      a_valid = 1'b1;
      a_pkt = mk(2, 3, 32'd100);
      tick();
      a_pkt = mk(2, 3, 32'd101);
      tick();
      a_grant = 1'b1;
      for (int k = 0; k < 10; k++) begin
         a_pkt = mk(2, 3, 32'(102 + k));
         chk("pp_head",  64'(a_out),   64'(mk(2, 3, 32'(100 + k))));
         chk("pp_ready", 64'(a_ready), 64'(1'b1));
         tick();
      end
      a_valid = 1'b0;
      for (int k = 110; k <= 111; k++) begin
         chk("pp_tail_out", 64'(a_out), 64'(mk(2, 3, 32'(k))));
         chk("pp_tail_req", 64'(a_req), 64'(5'b00100));
         tick();
      end
      a_grant = 1'b0;
      chk("pp_empty_req", 64'(a_req),  64'(5'b00000));
      chk("pp_gerr",      64'(a_gerr), 64'(1'b0));

      // Grant while empty is ignored but flagged, and the flag sticks
      a_grant = 1'b1;
      tick();
      a_grant = 1'b0;
      chk("gerr_set",   64'(a_gerr),  64'(1'b1));
      chk("gerr_req",   64'(a_req),   64'(5'b00000));
      chk("gerr_ready", 64'(a_ready), 64'(1'b1));
      tick();
      chk("gerr_sticky", 64'(a_gerr), 64'(1'b1));

      // U-turn on the east input: packet heading east again
      b_valid = 1'b1; b_pkt = mk(5, 1, 32'h77);
      tick();
      b_valid = 1'b0;
      chk("uturn_rerr", 64'(b_rerr), 64'(1'b1));
      chk("uturn_req",  64'(b_req),  64'(5'b01000));
      chk("uturn_out",  64'(b_out),  64'(mk(5, 1, 32'h77)));
      b_grant = 1'b1;
      tick();
      b_grant = 1'b0;
      chk("uturn_sticky", 64'(b_rerr), 64'(1'b1));
      b_valid = 1'b1; b_pkt = mk(0, 1, 32'h78);
      tick();
      b_valid = 1'b0;
      chk("west_req", 64'(b_req), 64'(5'b00010));

      // Reset mid-operation with three packets buffered
      a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_pkt = mk(0, 0, 32'(200 + i));
         tick();
      end
      a_valid = 1'b0;
      chk("mid_req", 64'(a_req), 64'(5'b00010));
      rst = 1'b1;
      tick();
      chk("mid_rst_ready", 64'(a_ready), 64'(1'b0));
      rst = 1'b0;
      #1;
      chk("mid_ready", 64'(a_ready), 64'(1'b1));
      chk("mid_req0",  64'(a_req),   64'(5'b00000));
      chk("mid_gerr",  64'(a_gerr),  64'(1'b0));
      chk("mid_b_rerr", 64'(b_rerr), 64'(1'b0));
      chk("mid_b_req", 64'(b_req),   64'(5'b00000));
      tick();
      chk("mid_idle_req", 64'(a_req), 64'(5'b00000));
      a_valid = 1'b1; a_pkt = mk(2, 2, 32'hBEEF);
      tick();
      a_valid = 1'b0;
      chk("mid_new_out", 64'(a_out), 64'(mk(2, 2, 32'hBEEF)));
      chk("mid_new_req", 64'(a_req), 64'(5'b10000));
      a_grant = 1'b1;
      tick();
      a_grant = 1'b0;
      chk("mid_no_stale", 64'(a_req), 64'(5'b00000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
